vga_vblank_arbiter: RTL and testbench
=====================================

// Module: vga_vblank_arbiter
// PURPOSE
//  Shares one frame-update resource (sprite/position registers, framebuffer write port) among
//  N_REQ game-logic requesters. Access is granted only while vga_timing reports vertical
//  blanking, so no visible line is drawn from half-updated state. Round-robin, one grant at a
//  time, each requester served at most once per frame, with per-grant cycle budget.
// PARAMETERS
//  N_REQ             4     number of requesters (>=2)
//  MAX_GRANT_CYCLES  1024  max cycles one grant may be held before forced release (>=2)
// PORTS
//  clk         in   1      pixel clock, same domain as vga_timing
//  rst         in   1      asynchronous, active-high reset
//  vblnk       in   1      vertical blank from vga_timing (registered there)
//  req         in   N_REQ  request, level; held until grant received and work finished
//  done        in   N_REQ  requester releases grant (1 cycle or level; only done[granted] used)
//  gnt         out  N_REQ  one-hot grant, registered
//  busy        out  1      =|gnt
//  frame_tick  out  1      1-cycle pulse at start of each vblank window
//  timeout     out  1      1-cycle pulse when a grant is revoked by budget or window close
// BEHAVIOUR
//  Reset (async, immediate, no clock needed): gnt=0, busy=0, frame_tick=0, timeout=0, state=IDLE,
//   served=0, ptr=0, timer=0, vblnk_q=0. All outputs registered; no comb path input->output.
//  vblnk_q <= vblnk each edge. Window open = vblnk sampled 1 at that edge.
//  States: IDLE, ARB, GRANT.
//  IDLE: edge sampling vblnk=1 while vblnk_q=0 -> frame_tick=1 (next cycle only), served=0, ARB.
//  ARB (per edge): vblnk=0 -> IDLE. Else eligible = req & ~served; if nonzero, grant first set
//   bit searching ptr, ptr+1, ... wrapping mod N_REQ; gnt one-hot, timer=0, -> GRANT.
//   Else stay ARB (late requests within window still served).
//  => first gnt rises 2 edges after first edge sampling vblnk=1.
//  GRANT, g = granted index, priority top to bottom:
//   1 done[g]=1 or req[g]=0 -> gnt=0, served[g]=1, ptr=(g+1) mod N_REQ, -> ARB. No timeout.
//   2 vblnk=0 -> gnt=0, served[g]=1, ptr=(g+1) mod N_REQ, timeout=1, -> IDLE.
//   3 timer==MAX_GRANT_CYCLES-1 -> gnt=0, served[g]=1, ptr advanced, timeout=1, -> ARB.
//   4 else timer+=1, gnt held.
//  => gnt held at most MAX_GRANT_CYCLES cycles; gnt low >=1 cycle between consecutive grants.
//  timer width $clog2(MAX_GRANT_CYCLES); never wraps (capped by rule 3).
//  ptr persists across frames (fairness over frames); served cleared only on frame_tick.
//  done/req on non-granted bits ignored. vblnk glitch-free by contract; a vblnk fall then rise
//   re-enters via IDLE and produces new frame_tick.
//  Reset mid-grant: gnt drops asynchronously; requester must tolerate loss of grant.
// TESTING (N_REQ=4, MAX_GRANT_CYCLES=8)
//  1 reset, vblnk=0, req=4'b1111 for 50 cycles -> gnt=0, busy=0, frame_tick=0 throughout.
//  2 vblnk 0->1, req=4'b0101 -> frame_tick 1 cycle; gnt=0001 2 edges after vblnk sampled;
//    done[0] pulse -> gnt=0 one cycle, then gnt=0100; done[2] -> gnt=0, stays ARB.
//  3 req[1] held, no done -> gnt=0010 exactly 8 cycles, timeout 1 pulse; req[1] not re-granted
//    until next frame_tick; next frame search starts at index 2.
//  4 req=1111 every frame, done after 3 cycles -> grant order 0,1,2,3 per frame; assert
//    $onehot0(gnt), gnt only when vblnk_q=1, no index granted twice per frame.
//  5 vblnk falls while gnt=0100 -> next edge gnt=0, timeout=1, IDLE; done+vblnk fall same edge
//    -> gnt=0, timeout=0.
//  6 rst asserted mid-grant between edges -> gnt=0 immediately; after release no gnt until
//    next vblnk rising edge, first grant to index 0.

Source files
------------

// File: rtl/vga_vblank_arbiter.sv
// Round-robin arbiter granting a shared frame-update resource only during vertical blanking.
// One grant at a time, each requester served at most once per frame, grant held within a budget.
module vga_vblank_arbiter #(
    parameter int unsigned N_REQ            = 4,
    parameter int unsigned MAX_GRANT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             frame_tick,
    output logic             timeout
);

    localparam int unsigned IdxW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TimerW = $clog2(MAX_GRANT_CYCLES);

    typedef enum logic [1:0] {StIdle, StArb, StGrant} state_e;

    state_e             state_q, state_d;
    logic               vblnk_q;
    logic [N_REQ-1:0]   served_q, served_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               busy_q;
    logic               frame_tick_q, frame_tick_d;
    logic               timeout_q, timeout_d;

    logic [N_REQ-1:0]   eligible;
    logic               pick_found;
    logic [IdxW-1:0]    pick_idx;
    logic [IdxW-1:0]    cand;
    logic [IdxW-1:0]    ptr_after;
    logic               finished;

    // First eligible requester at or after ptr, wrapping around.
    always_comb begin
        eligible   = req & ~served_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % N_REQ);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign ptr_after = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
    assign finished  = done[idx_q] | ~req[idx_q];

    always_comb begin
        state_d      = state_q;
        served_d     = served_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        gnt_d        = gnt_q;
        frame_tick_d = 1'b0;
        timeout_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (vblnk && !vblnk_q) begin
                    frame_tick_d = 1'b1;
                    served_d     = '0;
                    state_d      = StArb;
                end
            end
            StArb: begin
                if (!vblnk) begin
                    state_d = StIdle;
                end else if (pick_found) begin
                    idx_d   = pick_idx;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    timer_d = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (finished || !vblnk || timer_q == TimerW'(MAX_GRANT_CYCLES - 1)) begin
                    gnt_d           = '0;
                    served_d[idx_q] = 1'b1;
                    ptr_d           = ptr_after;
                    state_d         = StArb;
                    // A voluntary release wins over window close and budget expiry.
                    if (!finished) begin
                        timeout_d = 1'b1;
                        if (!vblnk) begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            vblnk_q      <= 1'b0;
            served_q     <= '0;
            ptr_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vblnk_q      <= vblnk;
            served_q     <= served_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            gnt_q        <= gnt_d;
            busy_q       <= |gnt_d;
            frame_tick_q <= frame_tick_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign frame_tick = frame_tick_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// Bench for vga_vblank_arbiter: directed scenarios then randomized frames, all cycles checked
// against a behavioural model of the vblank round-robin arbitration rules.
module tb_vga_vblank_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned MAXG = 8;

    logic          clk;
    logic          rst;
    logic          vblnk;
    logic [NR-1:0] req;
    logic [NR-1:0] done;
    logic [NR-1:0] gnt;
    logic          busy;
    logic          frame_tick;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    // Model: window open/closed, current owner (-1 none), cycles held, served set, next start.
    bit            m_window;
    int            m_owner;
    int            m_held;
    int            m_next;
    bit [NR-1:0]   m_served;
    bit            m_vq;
    logic [NR-1:0] exp_gnt;
    logic          exp_ft;
    logic          exp_to;

    int order[$];
    int hc;
    int cnt;

    vga_vblank_arbiter #(
        .N_REQ            (NR),
        .MAX_GRANT_CYCLES (MAXG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .busy       (busy),
        .frame_tick (frame_tick),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_window = 1'b0;
        m_owner  = -1;
        m_held   = 0;
        m_next   = 0;
        m_served = '0;
        m_vq     = 1'b0;
        exp_gnt  = '0;
        exp_ft   = 1'b0;
        exp_to   = 1'b0;
    endtask

    task automatic model_release();
        m_served[m_owner] = 1'b1;
        m_next            = (m_owner + 1) % NR;
        m_owner           = -1;
    endtask

    task automatic model_edge();
        bit found;
        int c;
        exp_ft = 1'b0;
        exp_to = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_window) begin
            if (vblnk && !m_vq) begin
                m_window = 1'b1;
                m_served = '0;
                exp_ft   = 1'b1;
            end
        end else if (m_owner < 0) begin
            if (!vblnk) begin
                m_window = 1'b0;
            end else begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    c = (m_next + k) % NR;
                    if (!found && req[c] && !m_served[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_held  = 1;
                    end
                end
            end
        end else begin
            if (done[m_owner] || !req[m_owner]) begin
                model_release();
            end else if (!vblnk) begin
                model_release();
                exp_to   = 1'b1;
                m_window = 1'b0;
            end else if (m_held == MAXG) begin
                model_release();
                exp_to = 1'b1;
            end else begin
                m_held++;
            end
        end
        m_vq    = vblnk;
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("busy", 32'(busy), 32'(exp_gnt != '0));
        check("frame_tick", 32'(frame_tick), 32'(exp_ft));
        check("timeout", 32'(timeout), 32'(exp_to));
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        check("gnt_in_window", 32'((gnt == '0) || m_vq), 32'd1);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) req = NR'($urandom);
            done = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
            tick();
        end
    endtask

    initial begin
        rst   = 1'b1;
        vblnk = 1'b0;
        req   = '1;
        done  = '0;
        model_reset();
        #2;
        check("reset_async", 32'({gnt, busy, frame_tick, timeout}), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // No window: nothing happens despite all requests.
        for (int i = 0; i < 50; i++) begin
            tick();
            check("t1_idle", 32'({gnt, busy, frame_tick}), 32'd0);
        end

        // Full frames, done after 3 cycles: order 0,1,2,3 each frame.
        for (int f = 0; f < 3; f++) begin
            vblnk = 1'b1;
            req   = '1;
            done  = '0;
            hc    = 0;
            order.delete();
            for (int i = 0; i < 40; i++) begin
                tick();
                if (gnt != '0) begin
                    if (hc == 0) order.push_back($clog2(gnt));
                    hc++;
                    done = (hc == 3) ? gnt : '0;
                end else begin
                    hc   = 0;
                    done = '0;
                end
            end
            check("t4_count", 32'(order.size()), 32'd4);
            for (int i = 0; i < 4; i++) begin
                if (i < order.size()) check("t4_order", 32'(order[i]), 32'(i));
            end
            vblnk = 1'b0;
            done  = '0;
            repeat (4) tick();
        end

        // Sparse requests 0101.
        vblnk = 1'b1;
        req   = 4'b0101;
        tick();
        check("t2_ft", 32'(frame_tick), 32'd1);
        check("t2_nognt", 32'(gnt), 32'd0);
        tick();
        check("t2_gnt0", 32'(gnt), 32'b0001);
        check("t2_ft_pulse", 32'(frame_tick), 32'd0);
        tick();
        tick();
        done = 4'b0001;
        tick();
        check("t2_gap", 32'(gnt), 32'd0);
        done = '0;
        tick();
        check("t2_gnt2", 32'(gnt), 32'b0100);
        done = 4'b0100;
        tick();
        check("t2_rel2", 32'(gnt), 32'd0);
        done = '0;
        repeat (3) tick();
        check("t2_arb_hold", 32'(gnt), 32'd0);

        // Budget expiry on requester 1.
        req = 4'b0010;
        tick();
        check("t3_gnt1", 32'(gnt), 32'b0010);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt == 4'b0010) cnt++;
            else break;
        end
        check("t3_timeout", 32'(timeout), 32'd1);
        check("t3_len", 32'(cnt), MAXG);
        tick();
        check("t3_to_pulse", 32'({gnt, timeout}), 32'd0);
        repeat (3) tick();
        check("t3_no_regrant", 32'(gnt), 32'd0);
        vblnk = 1'b0;
        tick();
        tick();
        req   = '1;
        vblnk = 1'b1;
        tick();
        check("t3_ft", 32'(frame_tick), 32'd1);
        tick();
        check("t3_start2", 32'(gnt), 32'b0100);

        // Window closes mid-grant, then done coincident with window close.
        vblnk = 1'b0;
        tick();
        check("t5_drop", 32'(gnt), 32'd0);
        check("t5_timeout", 32'(timeout), 32'd1);
        tick();
        vblnk = 1'b1;
        tick();
        tick();
        check("t5_gnt3", 32'(gnt), 32'b1000);
        done  = 4'b1000;
        vblnk = 1'b0;
        tick();
        check("t5_done_drop", 32'(gnt), 32'd0);
        check("t5_no_timeout", 32'(timeout), 32'd0);
        done = '0;
        tick();
        tick();

        // Reset between edges while granted.
        vblnk = 1'b1;
        tick();
        tick();
        check("t6_gnt0", 32'(gnt), 32'b0001);
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_async_gnt", 32'(gnt), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        vblnk = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("t6_quiet", 32'(gnt), 32'd0);
        vblnk = 1'b1;
        tick();
        check("t6_ft", 32'(frame_tick), 32'd1);
        tick();
        check("t6_first0", 32'(gnt), 32'b0001);

        // Randomized frames against the model.
        for (int f = 0; f < 25; f++) begin
            vblnk = 1'b0;
            rand_cycles($urandom_range(2, 6));
            vblnk = 1'b1;
            rand_cycles($urandom_range(8, 40));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
